sram_access_ctrl: RTL
=====================

SRAM_ACCESS_CTRL -- requirements
Module: sram_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4: SRAM address width (depth 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 8: SRAM and host data width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  input  1  host request present.
REQ-006 SHALL have port req_ready  output  1  controller accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_W  request address.
REQ-009 SHALL have port req_wdata  input  DATA_W  write data.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle completion pulse for reads and writes.
REQ-011 SHALL have port rsp_rdata  output  DATA_W  read data, valid while rsp_valid=1 after a read.
REQ-012 SHALL have port init_done  output  1  high once post-reset clear has finished.
REQ-013 SHALL have port read_write  output  1  SRAM command, 1 = write, 0 = read.
REQ-014 SHALL have port address  output  ADDR_W  SRAM address.
REQ-015 SHALL have port data_in  output  DATA_W  SRAM write data.
REQ-016 SHALL have port data_out  input  DATA_W  SRAM read data, registered by the SRAM one edge after the read command.

Function
REQ-017 SHALL implement FSM states INIT, IDLE, CMD, WAIT, RESP.
REQ-018 INIT SHALL drive read_write=1, data_in=0, address=init counter (0 up to 2**ADDR_W-1), one location per cycle.
REQ-019 INIT SHALL go to IDLE after the cycle with address=2**ADDR_W-1; init_done SHALL rise on that edge and stay high until reset.
REQ-020 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on an edge where req_valid=1 and req_ready=1.
REQ-021 On acceptance, req_we/req_addr/req_wdata SHALL be registered and the FSM SHALL go to CMD; later changes on req_* SHALL have no effect.
REQ-022 CMD SHALL last exactly one cycle, driving read_write=req_we, address=req_addr, data_in=req_wdata (registered).
REQ-023 Write path SHALL be CMD->RESP; read path SHALL be CMD->WAIT->RESP.
REQ-024 At the edge ending WAIT, data_out SHALL be captured into rsp_rdata.
REQ-025 RESP SHALL last one cycle with rsp_valid=1, then return to IDLE.
REQ-026 Latency SHALL be: write rsp_valid 2 cycles after the accept edge; read rsp_valid 3 cycles after the accept edge.
REQ-027 Throughput: the next request SHALL be accepted no earlier than the edge ending RESP+1 (the first IDLE cycle).
REQ-028 For writes, rsp_rdata SHALL hold its previous value.
REQ-029 Outside INIT and CMD, read_write SHALL be 0; address and data_in SHALL hold their last value.
REQ-030 req_valid during INIT, CMD, WAIT or RESP SHALL be ignored (not accepted, not queued).
REQ-031 Init counter SHALL be ADDR_W+1 bits wide so terminal detection needs no wrap.

Reset
REQ-032 While rst_n=0: state=INIT, init counter=0, init_done=0, req_ready=0, rsp_valid=0, rsp_rdata=0, read_write=0, address=0, data_in=0.
REQ-033 Reset asserted mid-transaction SHALL abort it without rsp_valid, and the full INIT clear SHALL restart after release.
REQ-034 The first INIT write SHALL occur in the first cycle after rst_n deasserts.

Structure
REQ-035 State encoding and the default ADDR_W/DATA_W SHALL live in shared package sram_pkg.
REQ-036 The design SHALL be a single module; the bench SHALL instantiate a behavioural model sram_model (synchronous write, registered read) as the responder.

Verification
REQ-037 Reset release with req_valid=0 -> 16 writes of 0 to addresses 0..15, init_done high at cycle 16, then req_ready=1.
REQ-038 Write addr=3 data=0xA5, then read addr=3 -> write rsp_valid 2 cycles after accept; read rsp_valid 3 cycles after accept with rsp_rdata=0xA5.
REQ-039 Read addr=9 right after init -> rsp_rdata=0x00.
REQ-040 req_valid held high during INIT and CMD -> only requests on IDLE edges accepted, exactly one rsp_valid per acceptance.
REQ-041 rst_n pulsed low during WAIT of a read -> no rsp_valid, outputs reset, INIT reruns and address 3 reads back 0x00.
REQ-042 Back-to-back writes addr=15 data=0xFF, addr=0 data=0x01, then read both -> 0xFF and 0x01, no wrap corruption.

Source files
------------

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Definitions shared by the SRAM access controller and anything that talks to
// it: the default SRAM geometry and the controller's state encoding.
// -----------------------------------------------------------------------------
package sram_pkg;

  // Default SRAM geometry: 2**SRAM_ADDR_W words of SRAM_DATA_W bits.
  localparam int unsigned SRAM_ADDR_W = 4;
  localparam int unsigned SRAM_DATA_W = 8;

  // Controller state encoding. Kept as plain constants so that older tools and
  // waveform scripts that match on raw values keep working.
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_INIT = 3'd0;  // clearing the SRAM after reset
  localparam logic [ST_W-1:0] ST_IDLE = 3'd1;  // ready for a host request
  localparam logic [ST_W-1:0] ST_CMD  = 3'd2;  // command on the SRAM pins
  localparam logic [ST_W-1:0] ST_WAIT = 3'd3;  // read data in flight
  localparam logic [ST_W-1:0] ST_RESP = 3'd4;  // completion pulse to the host

endpackage : sram_pkg

// File: rtl/sram_access_ctrl.sv
// -----------------------------------------------------------------------------
// sram_access_ctrl
// Single-request host front end for a synchronous SRAM with a registered read
// port. After reset it writes zero to every location, then serves one read or
// write at a time and reports completion with a one-cycle rsp_valid pulse.
//
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   req_valid/req_ready    host request handshake (accept when both are high)
//   req_we                 1 = write, 0 = read
//   req_addr, req_wdata    request address and write data
//   rsp_valid              one-cycle completion pulse for reads and writes
//   rsp_rdata              read data, updated only by reads
//   init_done              high once the post-reset clear has finished
//   read_write             SRAM command, 1 = write, 0 = read
//   address, data_in       SRAM address and write data (registered)
//   data_out               SRAM read data, valid one edge after the read command
// -----------------------------------------------------------------------------
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              read_write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out
);

  logic [ST_W-1:0]   state_q,      state_d;
  logic [ADDR_W:0]   init_cnt_q,   init_cnt_d;
  logic              init_done_q,  init_done_d;
  logic              rsp_valid_q,  rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q,  rsp_rdata_d;
  logic              read_write_q, read_write_d;
  logic [ADDR_W-1:0] address_q,    address_d;
  logic [DATA_W-1:0] data_in_q,    data_in_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    init_done_d  = init_done_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    read_write_d = 1'b0;        // SRAM is only commanded in INIT and CMD
    address_d    = address_q;   // address and data hold between commands
    data_in_d    = data_in_q;

    case (state_q)
      ST_INIT: begin
        // The counter is one bit wider than the address, so its MSB flags that
        // the last location was already issued without relying on a wrap.
        if (init_cnt_q[ADDR_W]) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end else begin
          read_write_d = 1'b1;
          address_d    = init_cnt_q[ADDR_W-1:0];
          data_in_d    = '0;
          init_cnt_d   = init_cnt_q + (ADDR_W+1)'(1);
        end
      end

      ST_IDLE: begin
        // Loading the request straight into the SRAM pin registers both
        // captures it and presents it during the single CMD cycle.
        if (req_valid) begin
          state_d      = ST_CMD;
          read_write_d = req_we;
          address_d    = req_addr;
          data_in_d    = req_wdata;
        end
      end

      ST_CMD: begin
        // read_write_q still carries the captured req_we during CMD.
        if (read_write_q) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // The SRAM registered the read on the edge that ended CMD, so data_out
        // is valid throughout WAIT.
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = data_out;
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      init_done_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      read_write_q <= 1'b0;
      address_q    <= '0;
      data_in_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, independent of statement order.
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      init_done_q  <= init_done_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      read_write_q <= read_write_d;
      address_q    <= address_d;
      data_in_q    <= data_in_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign init_done  = init_done_q;
  assign read_write = read_write_q;
  assign address    = address_q;
  assign data_in    = data_in_q;

endmodule : sram_access_ctrl
